ipf_feeder: RTL and testbench

Synthesizable sequencer that drives the IPF engine's load/compute protocol from a local SRAM. It reads the weight words and input words, then produces the exact w_valid/i_valid/ctrl/wround/wgroup sequence IPF expects for 3x3, 5x5 and 7x7 kernels at stride 1 or 2. It sits between the tile buffer and IPF and replaces bench-driven stimulus in the integrated datapath.

---
 rtl/ipf_pkg.sv | 39 +++
 rtl/ipf_feeder_cnt.sv | 73 +++++++
 rtl/ipf_feeder.sv | 242 ++++++++++++++++++++++++
 tb/tb_ipf_feeder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ipf_pkg.sv
// Shared encodings and per-kernel-size lookups for the IPF feeder.
package ipf_pkg;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_ADDR_W = 16;

    localparam logic [1:0] CTRL_END   = 2'd0;
    localparam logic [1:0] CTRL_START = 2'd1;
    localparam logic [1:0] CTRL_HOLD  = 2'd2;

    localparam logic [1:0] WS_3X3  = 2'd0;
    localparam logic [1:0] WS_5X5  = 2'd1;
    localparam logic [1:0] WS_7X7  = 2'd2;
    localparam logic [1:0] WS_RSVD = 2'd3;

    function automatic logic [4:0] w_cnt(input logic [1:0] ws);
        case (ws)
            WS_3X3:  return 5'd18;
            default: return 5'd25;
        endcase
    endfunction

    function automatic logic [2:0] pre_cnt(input logic [1:0] ws);
        case (ws)
            WS_3X3:  return 3'd2;
            WS_5X5:  return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

    function automatic logic [2:0] n_rounds(input logic [1:0] ws);
        case (ws)
            WS_3X3:  return 3'd1;
            WS_5X5:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ipf_feeder_cnt.sv
// Nested group/round/pass/word counters with last-flags for the IPF feeder.
module ipf_feed_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       adv_i,
    input  logic [3:0] pass_max_i,
    input  logic [1:0] round_max_i,
    input  logic [3:0] group_max_i,
    output logic [2:0] word_o,
    output logic [3:0] pass_o,
    output logic [1:0] round_o,
    output logic [3:0] group_o,
    output logic       word_last_o,
    output logic       pass_last_o,
    output logic       round_last_o,
    output logic       group_last_o
);

    logic [2:0] word_q, word_d;
    logic [3:0] pass_q, pass_d;
    logic [1:0] round_q, round_d;
    logic [3:0] group_q, group_d;

    assign word_last_o  = (word_q == 3'd7);
    assign pass_last_o  = (pass_q == pass_max_i);
    assign round_last_o = (round_q == round_max_i);
    assign group_last_o = (group_q == group_max_i);

    always_comb begin
        word_d  = word_q;
        pass_d  = pass_q;
        round_d = round_q;
        group_d = group_q;
        if (clr_i) begin
            word_d  = '0;
            pass_d  = '0;
            round_d = '0;
            group_d = '0;
        end else if (adv_i) begin
            word_d = word_q + 3'd1;
            if (word_last_o) begin
                pass_d = pass_last_o ? 4'd0 : pass_q + 4'd1;
                if (pass_last_o) begin
                    round_d = round_last_o ? 2'd0 : round_q + 2'd1;
                    if (round_last_o) begin
                        group_d = group_last_o ? 4'd0 : group_q + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            pass_q  <= '0;
            round_q <= '0;
            group_q <= '0;
        end else begin
            word_q  <= word_d;
            pass_q  <= pass_d;
            round_q <= round_d;
            group_q <= group_d;
        end
    end

    assign word_o  = word_q;
    assign pass_o  = pass_q;
    assign round_o = round_q;
    assign group_o = group_q;

endmodule

// File: rtl/ipf_feeder.sv
// Sequencer that streams weights then inputs from SRAM into the IPF load/compute protocol.
module ipf_feeder
    import ipf_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DRAIN_CYC = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cfg_wsize,
    input  logic              cfg_stride,
    input  logic [ADDR_W-1:0] cfg_wbase,
    input  logic [ADDR_W-1:0] cfg_ibase,
    input  logic [3:0]        cfg_npass,
    input  logic [3:0]        cfg_ngroups,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              w_valid,
    output logic [DATA_W-1:0] w_data,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_data,
    output logic [1:0]        ctrl,
    output logic [1:0]        Wsize,
    output logic              stride,
    output logic [2:0]        wround,
    output logic [3:0]        wgroup,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned AUX_W = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WLOAD = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_END   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [AUX_W-1:0]  aux_q, aux_d;
    logic [1:0]        wsize_q, wsize_d;
    logic              stride_q, stride_d;
    logic [ADDR_W-1:0] wbase_q, wbase_d;
    logic [ADDR_W-1:0] ibase_q, ibase_d;
    logic [3:0]        pass_max_q, pass_max_d;
    logic [3:0]        group_max_q, group_max_d;

    logic              w_valid_q, w_valid_d;
    logic              i_valid_q, i_valid_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [2:0]        wround_q, wround_d;
    logic [3:0]        wgroup_q, wgroup_d;

    logic              cnt_clr, cnt_adv;
    logic [2:0]        word;
    logic [3:0]        pass;
    logic [1:0]        round;
    logic [3:0]        group;
    logic              word_last, pass_last, round_last, group_last;

    logic [4:0]        wcnt_last;
    logic [2:0]        pre;
    logic [2:0]        pre_m1;
    logic [2:0]        rounds_m1;
    logic [ADDR_W-1:0] in_addr;

    assign wcnt_last = w_cnt(wsize_q) - 5'd1;
    assign pre       = pre_cnt(wsize_q);
    assign pre_m1    = pre - 3'd1;
    assign rounds_m1 = n_rounds(wsize_q) - 3'd1;
    assign in_addr   = ibase_q + {{(ADDR_W-3){1'b0}}, word};

    ipf_feed_cnt u_cnt (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (cnt_clr),
        .adv_i        (cnt_adv),
        .pass_max_i   (pass_max_q),
        .round_max_i  (rounds_m1[1:0]),
        .group_max_i  (group_max_q),
        .word_o       (word),
        .pass_o       (pass),
        .round_o      (round),
        .group_o      (group),
        .word_last_o  (word_last),
        .pass_last_o  (pass_last),
        .round_last_o (round_last),
        .group_last_o (group_last)
    );

    always_comb begin
        state_d     = state_q;
        aux_d       = aux_q;
        wsize_d     = wsize_q;
        stride_d    = stride_q;
        wbase_d     = wbase_q;
        ibase_d     = ibase_q;
        pass_max_d  = pass_max_q;
        group_max_d = group_max_q;
        cnt_clr     = 1'b0;
        cnt_adv     = 1'b0;
        mem_ren     = 1'b0;
        mem_addr    = '0;
        w_valid_d   = 1'b0;
        i_valid_d   = 1'b0;
        ctrl_d      = CTRL_HOLD;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wround_d    = wround_q;
        wgroup_d    = wgroup_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_wsize == WS_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        wsize_d     = cfg_wsize;
                        stride_d    = cfg_stride;
                        wbase_d     = cfg_wbase;
                        ibase_d     = cfg_ibase;
                        pass_max_d  = (cfg_npass == 4'd0) ? 4'd0 : cfg_npass - 4'd1;
                        // Stride 2 always runs a single group.
                        group_max_d = (cfg_stride || cfg_ngroups == 4'd0) ? 4'd0
                                                                          : cfg_ngroups - 4'd1;
                        aux_d       = '0;
                        cnt_clr     = 1'b1;
                        state_d     = S_WLOAD;
                    end
                end
            end
            S_WLOAD: begin
                mem_ren   = 1'b1;
                mem_addr  = wbase_q + {{(ADDR_W-AUX_W){1'b0}}, aux_q};
                w_valid_d = 1'b1;
                if (aux_q == {{(AUX_W-5){1'b0}}, wcnt_last}) begin
                    aux_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    aux_d = aux_q + 1'b1;
                end
            end
            S_HOLD: begin
                mem_ren   = 1'b1;
                mem_addr  = in_addr;
                i_valid_d = 1'b1;
                cnt_adv   = 1'b1;
                if (word == pre_m1) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                mem_ren   = 1'b1;
                mem_addr  = in_addr;
                i_valid_d = 1'b1;
                ctrl_d    = CTRL_START;
                cnt_adv   = 1'b1;
                // First START word of a round publishes the new round/group.
                if (pass == 4'd0 && word == pre) begin
                    wround_d = {1'b0, round};
                    wgroup_d = stride_q ? 4'd0 : group;
                end else if (stride_q) begin
                    wgroup_d = {3'b000, ~wgroup_q[0]};
                end
                if (word_last && pass_last) begin
                    state_d = (round_last && group_last) ? S_DRAIN : S_HOLD;
                end
            end
            S_DRAIN: begin
                if (aux_q == AUX_W'(DRAIN_CYC - 1)) begin
                    aux_d   = '0;
                    state_d = S_END;
                end else begin
                    aux_d = aux_q + 1'b1;
                end
            end
            S_END: begin
                ctrl_d  = CTRL_END;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            aux_q       <= '0;
            wsize_q     <= WS_3X3;
            stride_q    <= 1'b0;
            wbase_q     <= '0;
            ibase_q     <= '0;
            pass_max_q  <= '0;
            group_max_q <= '0;
            w_valid_q   <= 1'b0;
            i_valid_q   <= 1'b0;
            ctrl_q      <= CTRL_HOLD;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wround_q    <= '0;
            wgroup_q    <= '0;
        end else begin
            state_q     <= state_d;
            aux_q       <= aux_d;
            wsize_q     <= wsize_d;
            stride_q    <= stride_d;
            wbase_q     <= wbase_d;
            ibase_q     <= ibase_d;
            pass_max_q  <= pass_max_d;
            group_max_q <= group_max_d;
            w_valid_q   <= w_valid_d;
            i_valid_q   <= i_valid_d;
            ctrl_q      <= ctrl_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wround_q    <= wround_d;
            wgroup_q    <= wgroup_d;
        end
    end

    assign w_valid = w_valid_q;
    assign i_valid = i_valid_q;
    assign w_data  = w_valid_q ? mem_rdata : '0;
    assign i_data  = i_valid_q ? mem_rdata : '0;
    assign ctrl    = ctrl_q;
    assign Wsize   = wsize_q;
    assign stride  = stride_q;
    assign wround  = wround_q;
    assign wgroup  = wgroup_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ipf_feeder.sv
// Scoreboard bench for ipf_feeder: SRAM model returns address as data.
module tb_ipf_feeder;

    localparam int DRAIN = 10;

    typedef struct packed {
        logic        w;
        logic        i;
        logic [1:0]  ctrl;
        logic [2:0]  wr;
        logic [3:0]  wg;
        logic        done;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cfg_wsize = '0;
    logic        cfg_stride = 1'b0;
    logic [15:0] cfg_wbase = '0;
    logic [15:0] cfg_ibase = '0;
    logic [3:0]  cfg_npass = '0;
    logic [3:0]  cfg_ngroups = '0;
    logic        mem_ren;
    logic [15:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        w_valid, i_valid, stride, busy, done, err;
    logic [63:0] w_data, i_data;
    logic [1:0]  ctrl, Wsize;
    logic [2:0]  wround;
    logic [3:0]  wgroup;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int cyc = 0;
    int last_v = 0;
    logic [2:0] m_wr = '0;
    logic [3:0] m_wg = '0;
    beat_t exp_q[$];

    ipf_feeder #(.DATA_W(64), .ADDR_W(16), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_wsize(cfg_wsize), .cfg_stride(cfg_stride),
        .cfg_wbase(cfg_wbase), .cfg_ibase(cfg_ibase), .cfg_npass(cfg_npass),
        .cfg_ngroups(cfg_ngroups), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .w_valid(w_valid), .w_data(w_data), .i_valid(i_valid),
        .i_data(i_data), .ctrl(ctrl), .Wsize(Wsize), .stride(stride), .wround(wround),
        .wgroup(wgroup), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Non-address filler when not reading, so ungated data would show up.
    always @(posedge clk) mem_rdata <= mem_ren ? {48'h0, mem_addr} : 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic w, input logic i, input logic [1:0] c, input logic dn,
                        input logic [63:0] d);
        beat_t b;
        b.w = w; b.i = i; b.ctrl = c; b.wr = m_wr; b.wg = m_wg; b.done = dn; b.data = d;
        exp_q.push_back(b);
    endtask

    task automatic gen(input logic [1:0] ws, input logic st, input logic [15:0] wb,
                       input logic [15:0] ib, input logic [3:0] np, input logic [3:0] ng);
        int wc, pre, nr, npe, nge;
        wc  = (ws == 2'd0) ? 18 : 25;
        pre = (ws == 2'd0) ? 2 : (ws == 2'd1) ? 4 : 6;
        nr  = (ws == 2'd0) ? 1 : (ws == 2'd1) ? 2 : 4;
        npe = (np == 0) ? 1 : int'(np);
        nge = (st || ng == 0) ? 1 : int'(ng);
        for (int k = 0; k < wc; k++) push(1'b1, 1'b0, 2'd2, 1'b0, 64'(wb + 16'(k)));
        for (int g = 0; g < nge; g++)
            for (int r = 0; r < nr; r++)
                for (int p = 0; p < npe; p++)
                    for (int wd = 0; wd < 8; wd++) begin
                        if (p == 0 && wd < pre) begin
                            push(1'b0, 1'b1, 2'd2, 1'b0, 64'(ib + 16'(wd)));
                        end else begin
                            if (p == 0 && wd == pre) begin
                                m_wr = 3'(r);
                                m_wg = st ? 4'd0 : 4'(g);
                            end else if (st) begin
                                m_wg = {3'b000, ~m_wg[0]};
                            end
                            push(1'b0, 1'b1, 2'd1, 1'b0, 64'(ib + 16'(wd)));
                        end
                    end
        push(1'b0, 1'b0, 2'd0, 1'b1, 64'd0);
    endtask

    // Monitor: pops the scoreboard on every valid or done beat.
    always @(negedge clk) begin
        beat_t act, e;
        cyc++;
        if (!rst) begin
            if (err) err_cnt++;
            if (!w_valid) chk("w_data_gate", 128'(w_data), 128'd0);
            if (!i_valid) chk("i_data_gate", 128'(i_data), 128'd0);
            if (w_valid && i_valid) chk("valid_onehot", 128'd1, 128'd0);
            if (w_valid || i_valid || done) begin
                act = {w_valid, i_valid, ctrl, wround, wgroup, done, w_data | i_data};
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 128'(act), 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 128'(act), 128'(e));
                end
                if (done) chk("drain_gap", 128'(cyc - last_v), 128'(DRAIN + 1));
                if (w_valid || i_valid) last_v = cyc;
            end
        end
    end

    task automatic run_job(input logic [1:0] ws, input logic st, input logic [15:0] wb,
                           input logic [15:0] ib, input logic [3:0] np, input logic [3:0] ng,
                           input int exp_busy, input bit inject);
        int n;
        int e0;
        e0 = err_cnt;
        gen(ws, st, wb, ib, np, ng);
        cfg_wsize = ws; cfg_stride = st; cfg_wbase = wb; cfg_ibase = ib;
        cfg_npass = np; cfg_ngroups = ng;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            if (n == 0) begin
                chk("first_cycle_w_valid", 128'(w_valid), 128'd0);
                chk("Wsize_latched", 128'(Wsize), 128'(ws));
                chk("stride_latched", 128'(stride), 128'(st));
            end
            if (n == 1) chk("w_valid_latency", 128'(w_valid), 128'd1);
            if (inject && n == 30) begin
                start = 1'b1; cfg_wsize = 2'd3; cfg_ibase = 16'd999; cfg_npass = 4'd7;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        cfg_wsize = ws; cfg_ibase = ib; cfg_npass = np;
        chk("busy_len", 128'(n), 128'(exp_busy));
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        chk("no_err_in_job", 128'(err_cnt - e0), 128'd0);
    endtask

    initial begin
        int n;
        int e0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 128'(ctrl), 128'd2);
        chk("rst_outs", 128'({w_valid, i_valid, mem_ren, busy, done, err}), 128'd0);
        chk("rst_wr_wg", 128'({wround, wgroup}), 128'd0);
        chk("rst_data", 128'(w_data | i_data), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // 3x3 s1, 2 passes, 2 groups, with an ignored start mid-run.
        run_job(2'd0, 1'b0, 16'd0, 16'd32, 4'd2, 4'd2, 61, 1'b1);
        // 7x7 s1, single pass: four rounds of 6 HOLD + 2 START.
        run_job(2'd2, 1'b0, 16'd100, 16'd200, 4'd1, 4'd1, 68, 1'b0);
        // 5x5 s2: ngroups request is overridden to one group.
        run_job(2'd1, 1'b1, 16'd300, 16'd400, 4'd2, 4'd3, 68, 1'b0);
        // npass=0 and ngroups=0 behave as 1.
        run_job(2'd0, 1'b0, 16'd50, 16'd80, 4'd0, 4'd0, 18 + 8 + 11, 1'b0);

        // Reserved size is rejected.
        e0 = err_cnt;
        cfg_wsize = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reject_err_pulse", 128'(err), 128'd1);
        repeat (3) begin
            @(negedge clk);
            chk("reject_idle", 128'({busy, mem_ren, w_valid, i_valid}), 128'd0);
        end
        chk("reject_err_count", 128'(err_cnt - e0), 128'd1);

        // Reset during RUN word 5 of the first pass.
        gen(2'd0, 1'b0, 16'd0, 16'd32, 4'd2, 4'd2);
        cfg_wsize = 2'd0; cfg_stride = 1'b0; cfg_wbase = 16'd0; cfg_ibase = 16'd32;
        cfg_npass = 4'd2; cfg_ngroups = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mem_ren && mem_addr == 16'd37) && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("reach_run_word5", 128'(n < 200), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ctrl", 128'(ctrl), 128'd2);
        chk("midrst_outs", 128'({w_valid, i_valid, busy, done}), 128'd0);
        exp_q.delete();
        m_wr = '0;
        m_wg = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_job(2'd0, 1'b0, 16'd0, 16'd32, 4'd2, 4'd2, 61, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
